store_buffer: RTL and testbench

- Write-combining-free FIFO store buffer between the pipeline MEM stage and data_memory.
- Stores retire from the pipeline into the buffer in one cycle and drain to data_memory in order, one per cycle, whenever the memory write port is free and ready.
- Loads have priority on the memory port and read data_memory combinationally through this block.
- A load whose word overlaps any pending store stalls until that store has drained.

---
 rtl/store_buffer.sv | 127 ++++++++++++
 tb/tb_store_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of retired stores between the MEM stage and
// data_memory. Loads get the memory port first and read through
// combinationally. A load that overlaps a pending store's word stalls until
// that store has been written.
module store_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [2:0]               req_mode,
    input  logic [WIDTH-1:0]         req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    input  logic                     drain,
    output logic                     stall,
    output logic [WIDTH-1:0]         load_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         mem_A,
    output logic [WIDTH-1:0]         mem_WD,
    output logic                     mem_WE,
    output logic [2:0]               mem_mode,
    input  logic                     mem_wr_ready,
    input  logic [WIDTH-1:0]         mem_RD
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Loads from the trigger register never wait on buffered stores.
    localparam logic [WIDTH-1:0] MMIO_ADDR = WIDTH'(32'h100);

    // Buffer storage and bookkeeping
    logic [WIDTH-1:0] ent_addr [DEPTH];
    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [2:0]       ent_mode [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;

    logic is_load;
    logic addr_match;
    logic hazard;
    logic full;
    logic drain_block;
    logic load_go;
    logic pop;
    logic push;

    assign is_load     = req_valid & ~req_we;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign count       = count_q;
    assign drain_block = drain & ~empty;
    assign hazard      = is_load & addr_match & (req_addr != MMIO_ADDR);
    // The load path never depends on pop, so the port choice below has no
    // combinational loop through stall.
    assign load_go     = is_load & ~hazard & ~drain_block;
    assign pop         = mem_WE & mem_wr_ready;
    assign stall       = hazard | (req_valid & req_we & full & ~pop) | drain_block;
    assign push        = req_valid & req_we & ~stall & ~drain_block;
    assign load_data   = mem_RD;

    // Word-granular overlap check of the request against every pending store
    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        addr_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i][WIDTH-1:2] == req_addr[WIDTH-1:2])) begin
                addr_match = 1'b1;
            end
        end
    end

    // Memory port arbitration: a non-stalled load first, then the oldest store
    always_comb begin
        mem_A    = req_addr;
        mem_mode = req_mode;
        mem_WD   = '0;
        mem_WE   = 1'b0;
        if (!load_go && !empty) begin
            mem_A    = ent_addr[head];
            mem_WD   = ent_data[head];
            mem_mode = ent_mode[head];
            mem_WE   = 1'b1;
        end
    end

    // Pointers, occupancy and valid flags; reset drops every pending store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            ent_valid <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            if (pop) begin
                head            <= head + 1'b1;
                ent_valid[head] <= 1'b0;
            end
            // When full, tail equals head: this later write keeps the slot valid.
            if (push) begin
                tail            <= tail + 1'b1;
                ent_valid[tail] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload written at tail on push
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; ent_valid alone decides whether a slot is live.
        if (push) begin
            ent_addr[tail] <= req_addr;
            ent_data[tail] <= req_wdata;
            ent_mode[tail] <= req_mode;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a byte-addressed data_memory model plus a
// queue-based reference of pending stores, driven by directed scenarios and
// a randomized phase.
module tb_store_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [2:0]        req_mode = 3'b001;
    logic [WIDTH-1:0]  req_addr = '0;
    logic [WIDTH-1:0]  req_wdata = '0;
    logic              drain = 1'b0;
    logic              stall;
    logic [WIDTH-1:0]  load_data;
    logic              empty;
    logic [2:0]        count;
    logic [WIDTH-1:0]  mem_A;
    logic [WIDTH-1:0]  mem_WD;
    logic              mem_WE;
    logic [2:0]        mem_mode;
    logic              mem_wr_ready = 1'b0;
    logic [WIDTH-1:0]  mem_RD;
    logic              trigger = 1'b0;

    int errors = 0;
    int checks = 0;

    store_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .drain(drain), .stall(stall), .load_data(load_data), .empty(empty),
        .count(count), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
        .mem_mode(mem_mode), .mem_wr_ready(mem_wr_ready), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    // ---------------- data_memory environment ----------------
    // 256-byte window at 0x10000 (indexed by addr[7:0]); 0x100 is the trigger.
    logic [7:0]  dmem [256];
    logic        loaded = 1'b0;
    logic [31:0] wr_log [$];
    logic [31:0] env_word;

    function automatic logic [7:0] pre(int i);
        return 8'(i * 37 + 11);
    endfunction

    always_comb begin
        env_word = {dmem[mem_A[7:0] + 8'd3], dmem[mem_A[7:0] + 8'd2],
                    dmem[mem_A[7:0] + 8'd1], dmem[mem_A[7:0]]};
        case (mem_mode)
            3'b010:  mem_RD = {{16{env_word[15]}}, env_word[15:0]};
            3'b011:  mem_RD = {{24{env_word[7]}}, env_word[7:0]};
            3'b100:  mem_RD = {16'h0, env_word[15:0]};
            3'b101:  mem_RD = {24'h0, env_word[7:0]};
            default: mem_RD = env_word;
        endcase
        if (mem_A == 32'h100) mem_RD = {31'h0, trigger};
    end

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) dmem[i] <= pre(i);
            loaded <= 1'b1;
        end else if (mem_WE && mem_wr_ready && mem_A != 32'h100) begin
            wr_log.push_back(mem_A);
            dmem[mem_A[7:0]] <= mem_WD[7:0];
            if (mem_mode != 3'b011 && mem_mode != 3'b101)
                dmem[mem_A[7:0] + 8'd1] <= mem_WD[15:8];
            if (mem_mode == 3'b001) begin
                dmem[mem_A[7:0] + 8'd2] <= mem_WD[23:16];
                dmem[mem_A[7:0] + 8'd3] <= mem_WD[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  mode;
    } st_t;

    st_t        q [$];
    logic [7:0] ref_mem [256];

    function automatic int access_bytes(logic [2:0] m);
        if (m == 3'b001) return 4;
        if (m == 3'b010 || m == 3'b100) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a, logic [2:0] m);
        logic [31:0] v;
        int n;
        if (a == 32'h100) return {31'h0, trigger};
        n = access_bytes(m);
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[8'(a[7:0] + 8'(k))];
        if (m == 3'b010 && v[15]) v[31:16] = '1;
        if (m == 3'b011 && v[7])  v[31:8]  = '1;
        return v;
    endfunction

    task automatic ref_write(st_t s);
        if (s.addr != 32'h100)
            for (int k = 0; k < access_bytes(s.mode); k++)
                ref_mem[8'(s.addr[7:0] + 8'(k))] = s.data[8*k +: 8];
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare the
    // combinational outputs against the model, then advance the model to
    // match the coming rising edge.
    task automatic step(input logic v, input logic we, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic dr, input logic rdy, input string tag);
        logic haz, e_empty, e_full, dblk, load_go, e_we, e_pop, e_stall, e_push;
        st_t s;
        @(negedge clk);
        req_valid = v; req_we = we; req_mode = m; req_addr = a;
        req_wdata = d; drain = dr; mem_wr_ready = rdy;
        #1;
        haz = 1'b0;
        if (v && !we && a != 32'h100)
            foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) haz = 1'b1;
        e_empty = (q.size() == 0);
        e_full  = (q.size() == DEPTH);
        dblk    = dr && !e_empty;
        load_go = v && !we && !haz && !dblk;
        e_we    = !load_go && !e_empty;
        e_pop   = e_we && rdy;
        e_stall = haz || (v && we && e_full && !e_pop) || dblk;
        e_push  = v && we && !e_stall;

        check({tag, "/stall"},  32'(stall),  32'(e_stall));
        check({tag, "/mem_WE"}, 32'(mem_WE), 32'(e_we));
        check({tag, "/count"},  32'(count),  32'(q.size()));
        check({tag, "/empty"},  32'(empty),  32'(e_empty));
        if (load_go) check({tag, "/load_data"}, load_data, ref_read(a, m));
        if (e_we) begin
            check({tag, "/mem_A"},  mem_A,  q[0].addr);
            check({tag, "/mem_WD"}, mem_WD, q[0].data);
        end

        if (e_pop) begin
            ref_write(q[0]);
            void'(q.pop_front());
        end
        if (e_push) begin
            s.addr = a; s.data = d; s.mode = m;
            q.push_back(s);
        end
    endtask

    task automatic idle(input logic rdy, input string tag);
        step(1'b0, 1'b0, 3'b001, 32'h10000, 32'h0, 1'b0, rdy, tag);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input string tag);
        step(1'b1, 1'b1, 3'b001, a, d, 1'b0, rdy, tag);
    endtask

    // Watchdog: the sequence has no open-ended waits, but never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_log [5];
        for (int i = 0; i < 256; i++) ref_mem[i] = pre(i);

        // Reset state
        @(negedge clk); #1;
        check("reset/count",  32'(count),  32'd0);
        check("reset/empty",  32'(empty),  32'd1);
        check("reset/stall",  32'(stall),  32'd0);
        check("reset/mem_WE", 32'(mem_WE), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-operation discards pending stores
        sw(32'h10000, 32'hAAAA0000, 1'b0, "rst_sw0");
        sw(32'h10004, 32'hAAAA0004, 1'b0, "rst_sw1");
        sw(32'h10008, 32'hAAAA0008, 1'b0, "rst_sw2");
        idle(1'b0, "rst_hold");
        check("rst_pending/count", 32'(count), 32'd3);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid/count",  32'(count),  32'd0);
        check("rst_mid/empty",  32'(empty),  32'd1);
        check("rst_mid/mem_WE", 32'(mem_WE), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 3'b001, 32'h10000, 32'h0, 1'b0, 1'b1, "rst_load");
        check("rst_load/preload", load_data, 32'h7A55300B);

        // Fill, then a 5th store accepted only alongside a pop
        wr_log.delete();
        sw(32'h10000, 32'hD0D0D0D0, 1'b0, "full_sw0");
        sw(32'h10004, 32'hD1D1D1D1, 1'b0, "full_sw1");
        sw(32'h10008, 32'hD2D2D2D2, 1'b0, "full_sw2");
        sw(32'h1000C, 32'hD3D3D3D3, 1'b0, "full_sw3");
        sw(32'h10010, 32'hD4D4D4D4, 1'b0, "full_sw4_blocked");
        check("full/count4", 32'(count), 32'd4);
        check("full/stall5", 32'(stall), 32'd1);
        sw(32'h10010, 32'hD4D4D4D4, 1'b1, "full_sw4_accept");
        check("full/accept_stall", 32'(stall), 32'd0);
        idle(1'b1, "full_drain0");
        check("full/count_held", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) idle(1'b1, "full_drain");
        check("full/log_size", 32'(wr_log.size()), 32'd5);
        exp_log = '{32'h10000, 32'h10004, 32'h10008, 32'h1000C, 32'h10010};
        for (int i = 0; i < 5 && i < wr_log.size(); i++)
            check("full/order", wr_log[i], exp_log[i]);

        // Overlapping byte load waits for the store to drain
        sw(32'h10010, 32'hDEADBEEF, 1'b0, "haz_sw");
        step(1'b1, 1'b0, 3'b101, 32'h10012, 32'h0, 1'b0, 1'b0, "haz_lbu0");
        check("haz/stall_pending", 32'(stall), 32'd1);
        step(1'b1, 1'b0, 3'b101, 32'h10012, 32'h0, 1'b0, 1'b1, "haz_lbu1");
        step(1'b1, 1'b0, 3'b101, 32'h10012, 32'h0, 1'b0, 1'b1, "haz_lbu2");
        check("haz/stall_clear", 32'(stall), 32'd0);
        check("haz/lbu_data", load_data, 32'h000000AD);

        // Non-overlapping load bypasses a pending store
        sw(32'h10020, 32'h12345678, 1'b0, "byp_sw");
        step(1'b1, 1'b0, 3'b001, 32'h10040, 32'h0, 1'b0, 1'b1, "byp_lw");
        check("byp/stall",  32'(stall),  32'd0);
        check("byp/mem_WE", 32'(mem_WE), 32'd0);
        check("byp/count",  32'(count),  32'd1);
        idle(1'b1, "byp_idle");
        check("byp/drain_we", 32'(mem_WE), 32'd1);
        idle(1'b1, "byp_after");
        check("byp/empty", 32'(empty), 32'd1);

        // Trigger MMIO load ignores a pending store to the same address
        trigger = 1'b1;
        sw(32'h100, 32'h00000055, 1'b0, "mmio_sw");
        step(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 1'b0, 1'b0, "mmio_lw");
        check("mmio/stall", 32'(stall), 32'd0);
        check("mmio/data",  load_data, 32'h00000001);
        idle(1'b1, "mmio_drain");

        // Fence holds stall until the buffer is empty
        sw(32'h10030, 32'hCAFE0030, 1'b0, "fence_sw0");
        sw(32'h10034, 32'hCAFE0034, 1'b0, "fence_sw1");
        step(1'b0, 1'b0, 3'b001, 32'h0, 32'h0, 1'b1, 1'b1, "fence0");
        check("fence/stall0", 32'(stall), 32'd1);
        step(1'b0, 1'b0, 3'b001, 32'h0, 32'h0, 1'b1, 1'b1, "fence1");
        check("fence/stall1", 32'(stall), 32'd1);
        step(1'b0, 1'b0, 3'b001, 32'h0, 32'h0, 1'b1, 1'b1, "fence2");
        check("fence/stall2", 32'(stall), 32'd0);
        check("fence/empty",  32'(empty), 32'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic        v, we, dr, rdy;
            logic [2:0]  m;
            logic [31:0] a;
            int          sel;
            v   = ($urandom_range(0, 9) < 7);
            we  = $urandom_range(0, 1) == 1;
            dr  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            sel = $urandom_range(0, 4);
            m   = (sel == 0) ? 3'b001 : (sel == 1) ? 3'b010 : (sel == 2) ? 3'b011 :
                  (sel == 3) ? 3'b100 : 3'b101;
            if (we && m > 3'b011) m = m - 3'b010;
            a = 32'h10000 + ($urandom_range(0, 15) << 2);
            if (access_bytes(m) == 2) a = a + ($urandom_range(0, 1) << 1);
            if (access_bytes(m) == 1) a = a + $urandom_range(0, 3);
            if (!we && $urandom_range(0, 9) == 0) a = 32'h100;
            step(v, we, m, a, $urandom, dr, rdy, "rand");
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1, "final_drain");
        check("final/empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
